// File: rtl/rob_multi_port_if.sv
// Bundle for rob_multi_port covering the rename (allocation), writeback,
// commit (retire/flush) and status signals. The master modport is the
// pipeline side; the slave modport is the reorder buffer itself.
interface rob_multi_port_if #(
  parameter int DEPTH        = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int RENAME_WIDTH = 4,
  parameter int WB_WIDTH     = 4,
  parameter int COMMIT_WIDTH = 4
);
  localparam int ID_WIDTH = $clog2(DEPTH);

  // Allocation (rename)
  logic [RENAME_WIDTH-1:0]            alloc_req;
  logic [RENAME_WIDTH*DATA_WIDTH-1:0] alloc_data;
  logic                               alloc_ready;
  logic [RENAME_WIDTH*ID_WIDTH-1:0]   alloc_id;

  // Writeback (completion)
  logic [WB_WIDTH-1:0]                wb_we;
  logic [WB_WIDTH*ID_WIDTH-1:0]       wb_id;
  logic [WB_WIDTH*DATA_WIDTH-1:0]     wb_data;

  // Commit (retire / flush)
  logic [COMMIT_WIDTH-1:0]            retire_valid;
  logic [COMMIT_WIDTH*ID_WIDTH-1:0]   retire_id;
  logic [COMMIT_WIDTH*DATA_WIDTH-1:0] retire_data;
  logic [COMMIT_WIDTH-1:0]            retire_pop;
  logic                               flush_all;
  logic                               flush_partial;
  logic [ID_WIDTH-1:0]                flush_id;

  // Occupancy status
  logic [ID_WIDTH:0]                  count;
  logic                               empty;
  logic                               full;

  modport master (
    output alloc_req, alloc_data, wb_we, wb_id, wb_data,
           retire_pop, flush_all, flush_partial, flush_id,
    input  alloc_ready, alloc_id, retire_valid, retire_id, retire_data,
           count, empty, full
  );

  modport slave (
    input  alloc_req, alloc_data, wb_we, wb_id, wb_data,
           retire_pop, flush_all, flush_partial, flush_id,
    output alloc_ready, alloc_id, retire_valid, retire_id, retire_data,
           count, empty, full
  );
endinterface

// File: rtl/rob_multi_port.sv
// rob_multi_port: parametrised multi-lane reorder buffer with all-or-nothing
// allocation, per-entry done tracking, full and tail-truncating flush, and
// an occupancy count. Pointers carry a wrap bit so count = wptr - rptr.
// Optional: define ROB_PERF_CNT_EN to add the perf_retired and
// perf_alloc_stall 32-bit wrapping counters.
module rob_multi_port #(
  parameter int DEPTH        = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int RENAME_WIDTH = 4,
  parameter int WB_WIDTH     = 4,
  parameter int COMMIT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  rob_multi_port_if.slave        bus
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]            perf_retired,
  output logic [31:0]            perf_alloc_stall
`endif
);
  localparam int ID_WIDTH = $clog2(DEPTH);

  typedef logic [ID_WIDTH-1:0]   id_t;
  typedef logic [ID_WIDTH:0]     ptr_t;
  typedef logic [DATA_WIDTH-1:0] data_t;

  ptr_t             rptr;
  ptr_t             wptr;
  logic [DEPTH-1:0] done;
  data_t            mem [DEPTH];

  ptr_t                    count_w;
  ptr_t                    alloc_cnt;
  logic                    alloc_fire;
  logic [COMMIT_WIDTH-1:0] rv;
  ptr_t                    pops;
  ptr_t                    pops_eff;
  ptr_t                    flush_age;
  ptr_t                    kept;
  logic                    flush_hit;
  ptr_t                    wb_limit;
  logic [WB_WIDTH-1:0]     wb_ok;

  // Distance of an id from the head; an id is live when this is below count.
  function automatic ptr_t age_of(input id_t id, input ptr_t head);
    return {1'b0, id - head[ID_WIDTH-1:0]};
  endfunction

  assign count_w   = wptr - rptr;
  assign bus.count = count_w;
  assign bus.empty = (count_w == '0);
  assign bus.full  = (count_w == ptr_t'(DEPTH));

  // Compact the requesting lanes onto consecutive ids starting at the tail.
  always_comb begin
    // NOTE: defaults first so no path leaves a combinational output unassigned (no latch).
    alloc_cnt    = '0;
    bus.alloc_id = '0;
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      bus.alloc_id[l*ID_WIDTH +: ID_WIDTH] = wptr[ID_WIDTH-1:0] + alloc_cnt[ID_WIDTH-1:0];
      // NOTE: blocking '=' here so the running count feeds the next lane in the same pass.
      if (bus.alloc_req[l]) alloc_cnt = alloc_cnt + ptr_t'(1);
    end
  end

  assign bus.alloc_ready = (alloc_cnt <= ptr_t'(DEPTH) - count_w)
                           && !bus.flush_all && !bus.flush_partial;
  assign alloc_fire      = bus.alloc_ready && (|bus.alloc_req);

  // Retire window: a prefix of live, done entries, then the leading run of pops.
  always_comb begin
    id_t  rid;
    logic run;
    rid             = '0;
    run             = 1'b1;
    rv              = '0;
    pops            = '0;
    bus.retire_id   = '0;
    bus.retire_data = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      rid   = rptr[ID_WIDTH-1:0] + id_t'(k);
      rv[k] = run && (ptr_t'(k) < count_w) && done[rid];
      run   = rv[k];
      bus.retire_id[k*ID_WIDTH +: ID_WIDTH]       = rid;
      bus.retire_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rid];
    end
    run = 1'b1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      run = run && rv[k] && bus.retire_pop[k];
      if (run) pops = pops + ptr_t'(1);
    end
  end

  assign bus.retire_valid = rv;

  // Partial flush keeps [rptr, flush_id]; pops may not run past the new tail.
  assign flush_age = age_of(bus.flush_id, rptr);
  assign flush_hit = bus.flush_partial && (flush_age < count_w);
  assign kept      = flush_age + ptr_t'(1);
  assign pops_eff  = (flush_hit && (pops > kept)) ? kept : pops;
  assign wb_limit  = flush_hit ? kept : count_w;

  // A writeback lands only on a live (and, under partial flush, kept) entry.
  always_comb begin
    wb_ok = '0;
    for (int l = 0; l < WB_WIDTH; l++) begin
      wb_ok[l] = bus.wb_we[l] && !bus.flush_all
                 && (age_of(bus.wb_id[l*ID_WIDTH +: ID_WIDTH], rptr) < wb_limit);
    end
  end

  // Pointer and done-bit state; flush_all overrides everything else.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rptr <= '0;
      wptr <= '0;
      done <= '0;
    end else if (bus.flush_all) begin
      rptr <= '0;
      wptr <= '0;
      done <= '0;
    end else begin
      rptr <= rptr + pops_eff;
      if (flush_hit)       wptr <= rptr + kept;
      else if (alloc_fire) wptr <= wptr + alloc_cnt;
      for (int i = 0; i < DEPTH; i++) begin
        if (flush_hit && (age_of(id_t'(i), rptr) >= kept)) done[i] <= 1'b0;
      end
      // Later lanes overwrite earlier ones, so the highest lane wins.
      for (int l = 0; l < WB_WIDTH; l++) begin
        if (wb_ok[l]) done[bus.wb_id[l*ID_WIDTH +: ID_WIDTH]] <= 1'b1;
      end
      for (int l = 0; l < RENAME_WIDTH; l++) begin
        if (alloc_fire && bus.alloc_req[l]) done[bus.alloc_id[l*ID_WIDTH +: ID_WIDTH]] <= 1'b0;
      end
    end
  end

  // Payload RAM; allocation ids never overlap live writeback ids.
  // NOTE: payload storage has no reset; done bits alone decide validity.
  always_ff @(posedge clk) begin
    for (int l = 0; l < WB_WIDTH; l++) begin
      if (wb_ok[l]) mem[bus.wb_id[l*ID_WIDTH +: ID_WIDTH]] <= bus.wb_data[l*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int l = 0; l < RENAME_WIDTH; l++) begin
      if (alloc_fire && bus.alloc_req[l]) begin
        mem[bus.alloc_id[l*ID_WIDTH +: ID_WIDTH]] <= bus.alloc_data[l*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  // Wrapping performance counters, untouched by flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_retired     <= '0;
      perf_alloc_stall <= '0;
    end else begin
      if (!bus.flush_all) perf_retired <= perf_retired + 32'(pops_eff);
      if ((|bus.alloc_req) && !bus.alloc_ready) perf_alloc_stall <= perf_alloc_stall + 32'd1;
    end
  end
`endif

endmodule

// File: doc/rob_multi_port.md
Name: rob_multi_port

Overview:
Parametrised reorder buffer, the successor to the fixed-size ROB. Width, depth and channel counts are all generic. The block adds:
- an all-or-nothing allocation handshake,
- per-entry completion (done) tracking, so retire_valid already means "done",
- partial (tail-truncating) flush beside full flush,
- an occupancy count output.

It sits between rename (allocation), writeback (completion) and commit (retire/flush).

Parameters:
DEPTH, 32, entry count; power of two, >= 4.
ID_WIDTH, $clog2(DEPTH), entry index width; derived, not overridden.
DATA_WIDTH, 64, opaque payload bits per entry.
RENAME_WIDTH, 4, allocation lanes.
WB_WIDTH, 4, writeback lanes.
COMMIT_WIDTH, 4, retire lanes.

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
alloc_req  in  RENAME_WIDTH  lanes requesting an entry
alloc_data  in  RENAME_WIDTH*DATA_WIDTH  payload per lane
alloc_ready  out  1  all requested lanes fit and no flush is active
alloc_id  out  RENAME_WIDTH*ID_WIDTH  id assigned per lane
wb_we  in  WB_WIDTH  writeback enable per lane
wb_id  in  WB_WIDTH*ID_WIDTH  target entry
wb_data  in  WB_WIDTH*DATA_WIDTH  new payload; also sets done
retire_valid  out  COMMIT_WIDTH  head+k is in range, done, and lanes 0..k-1 are valid
retire_id  out  COMMIT_WIDTH*ID_WIDTH  head+k
retire_data  out  COMMIT_WIDTH*DATA_WIDTH  payload of head+k
retire_pop  in  COMMIT_WIDTH  pop request per lane
flush_all  in  1  discard every entry
flush_partial  in  1  discard entries younger than flush_id
flush_id  in  ID_WIDTH  youngest entry kept
count  out  ID_WIDTH+1  occupancy, 0..DEPTH
empty  out  1  count==0
full  out  1  count==DEPTH

Behaviour:
- Pointers: rptr and wptr are ID_WIDTH+1 bits with a wrap bit. count = wptr - rptr.
- Reset (rst=0 at edge): rptr=wptr=0; all done bits cleared. Payload RAM is not reset.
- Outputs after reset: alloc_ready=1, retire_valid=0, count=0, empty=1, full=0.
- Allocation ids: lanes are compacted in lane order. The j-th set lane of alloc_req gets id wptr[ID_WIDTH-1:0]+j; the addition wraps modulo DEPTH. alloc_id of unset lanes is don't-care.
- alloc_ready = (popcount(alloc_req) <= DEPTH-count) && !flush_all && !flush_partial. It is combinational and does not depend on retire_pop in the same cycle.
- Allocation commit: when alloc_ready && |alloc_req, at the edge wptr += popcount, the payloads are written, and the allocated done bits are cleared. Otherwise nothing is allocated (no partial allocation).
- Writeback: applies at the edge only when wb_id is within [rptr,wptr). It writes the payload and sets done.
  - Writebacks outside the range are ignored.
  - If several lanes hit the same id, the highest lane index wins.
- Retire:
  - retire_valid[k] is a prefix mask.
  - Effective pops = the length of the leading run of lanes where retire_pop[k] && retire_valid[k]. Any set bit after a gap is ignored.
  - At the edge rptr += effective pops.
  - Latency: alloc accepted at edge N, wb at edge N+1, retire_valid high in the cycle after edge N+1.
- flush_all has highest priority: at the edge rptr=wptr=0 and done bits are cleared. Pops, writebacks and allocations in that cycle are discarded.
- flush_partial, when flush_id is within [rptr,wptr):
  - wptr becomes the pointer of flush_id+1, keeping the wrap bit consistent with rptr. Done bits of the discarded entries are cleared.
  - Retire pops in the same cycle still apply.
  - A writeback in the same cycle applies only to kept ids.
  - Allocation is blocked (alloc_ready=0).
  - If flush_id is out of range, the flush is a no-op apart from blocking allocation.
- Wrap-around: ids wrap modulo DEPTH; in-range tests use the wrap bit. With count==DEPTH every id is in range.
- Simultaneous pop and allocate at full: allocation is still refused in that cycle.

Optional Feature:
ROB_PERF_CNT_EN:
- Adds 32-bit outputs perf_retired (sum of effective pops) and perf_alloc_stall (cycles with |alloc_req && !alloc_ready).
- Both counters wrap at 2^32, reset to 0 on rst, and are not cleared by flush.
- Without the macro, the ports and logic are absent.

Test Plan:
1. Reset, then alloc_req=4'b1111 -> alloc_ready=1, ids 0,1,2,3. Next cycle count=4, retire_valid=0.
2. wb to ids 1,0 in one cycle, then pop 4'b0011 -> retire_valid=4'b0011 with retire_data equal to the wb payloads. After the pop, count=2 and head id=2.
3. Fill to DEPTH=32, then alloc_req=4'b0001 with retire_pop=1 on a done head -> alloc_ready=0 in that cycle. Next cycle count=31 and alloc_ready=1.
4. Wrap: head=30, allocate 4 -> ids 30,31,0,1. Mark all done -> retire_valid=4'b1111 and retire_id=30,31,0,1.
5. Entries 5..12 present, flush_partial with flush_id=8 while popping 1 done head -> count=3 (ids 6..8). A wb to id 10 in the same cycle is ignored, and the next allocation returns id 9.
6. flush_all asserted together with alloc_req and wb -> count=0, empty=1. No entry gets done and the next allocation returns id 0.
